// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC / fetch-sequencing stage: FSM encoding,
// reset vector default, PC step and control-field widths.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_BUBBLE = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP              = 32'd4;
    localparam int          JUMP_TARGET_W        = 26;
    localparam int          BRANCH_OFFSET_W      = 32;

    // J-type target: keep the region bits of pc4, splice in the word index.
    function automatic logic [31:0] jump_addr(input logic [31:0]              pc4,
                                              input logic [JUMP_TARGET_W-1:0] tgt);
        return {pc4[31:28], tgt, 2'b00};
    endfunction

    // Branch target: word offset scaled to bytes, modulo 2^32.
    function automatic logic [31:0] branch_addr(input logic [31:0]                pc4,
                                                input logic [BRANCH_OFFSET_W-1:0] off);
        return pc4 + {off[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_next_calc.sv
// Combinational next-PC resolution. Selects jump > taken branch > sequential
// and flags a redirect when a qualified jump or taken branch is present.
module pc_next_calc
    import pc_fetch_unit_pkg::*;
(
    input  logic [31:0]                pc_i,
    input  logic [31:0]                instr_pc_i,
    input  logic                       resolve_valid_i,
    input  logic                       branch_eq_i,
    input  logic                       branch_ne_i,
    input  logic                       alu_zero_i,
    input  logic [BRANCH_OFFSET_W-1:0] branch_offset_i,
    input  logic                       jump_i,
    input  logic [JUMP_TARGET_W-1:0]   jump_target_i,
    output logic [31:0]                next_pc_o,
    output logic                       redirect_o
);

    logic [31:0] pc4;
    logic        taken;
    logic        do_jump;
    logic        do_branch;

    assign pc4       = instr_pc_i + PC_STEP;
    assign taken     = (branch_eq_i & alu_zero_i) | (branch_ne_i & ~alu_zero_i);
    assign do_jump   = resolve_valid_i & jump_i;
    assign do_branch = resolve_valid_i & taken;

    // Priority select of the following PC; redirect covers both non-sequential cases.
    always_comb begin
        next_pc_o  = pc_i + PC_STEP;
        redirect_o = 1'b0;
        if (do_jump) begin
            next_pc_o  = jump_addr(pc4, jump_target_i);
            redirect_o = 1'b1;
        end else if (do_branch) begin
            next_pc_o  = branch_addr(pc4, branch_offset_i);
            redirect_o = 1'b1;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer feeding instruction memory.
// FSM IDLE -> FETCH <-> BUBBLE; one squash bubble follows every redirect.
// Optional accepted-fetch counter enabled by defining FETCH_PERF_COUNT_EN;
// otherwise fetch_count is tied to zero.
//
// Handshake: a fetch transfers on a rising edge where fetch_valid and
// fetch_ready are both high. While fetch_valid is high and not yet accepted,
// fetch_addr is held stable. fetch_valid is dropped in a redirect cycle so the
// wrong-path address can never be accepted.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int          ADDR_W       = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [ADDR_W-1:0]          fetch_addr,
    output logic                       fetch_valid,
    input  logic                       fetch_ready,
    output logic [ADDR_W-1:0]          instr_pc,
    input  logic                       resolve_valid,
    input  logic                       branch_eq,
    input  logic                       branch_ne,
    input  logic                       alu_zero,
    input  logic [BRANCH_OFFSET_W-1:0] branch_offset,
    input  logic                       jump,
    input  logic [JUMP_TARGET_W-1:0]   jump_target,
    output logic [31:0]                fetch_count
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [ADDR_W-1:0] next_pc;
    logic              redirect;
    logic              accept;

    pc_next_calc u_next (
        .pc_i            (pc_q),
        .instr_pc_i      (instr_pc_q),
        .resolve_valid_i (resolve_valid),
        .branch_eq_i     (branch_eq),
        .branch_ne_i     (branch_ne),
        .alu_zero_i      (alu_zero),
        .branch_offset_i (branch_offset),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .next_pc_o       (next_pc),
        .redirect_o      (redirect)
    );

    // Next-state, PC update and handshake decode.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_pc_d  = instr_pc_q;
        fetch_valid = 1'b0;
        accept      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect) begin
                    pc_d    = next_pc;
                    state_d = ST_BUBBLE;
                end else begin
                    fetch_valid = 1'b1;
                    if (fetch_ready) begin
                        accept     = 1'b1;
                        instr_pc_d = pc_q;
                        pc_d       = next_pc;
                    end
                end
            end
            ST_BUBBLE: begin
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, PC and decode-PC registers; reset wins over any pending redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_VECTOR;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign fetch_addr = pc_q;
    assign instr_pc   = instr_pc_q;

`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    // Accepted-fetch counter, wraps naturally at 2^32.
    always_comb begin
        fetch_count_d = fetch_count_q;
        if (accept) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign fetch_count   = 32'h0;
`endif

endmodule
